// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
package rf_pkg;

  localparam int RF_AW = 4;
  localparam int RF_DW = 8;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = '0;

  // One buffered write-back request.
  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_skid.sv
// Single-entry skid buffer for one write-back requester.
// The ready output depends only on the held entry and the grant, never on vld.
// Writes to r0 are accepted and dropped, because r0 reads as zero.
module wb_skid
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [RF_AW-1:0] wa,
  input  logic [RF_DW-1:0] wd,
  input  logic             gnt,
  output logic             rdy,
  output wb_req_t          q
);

  // Space is available when the buffer is empty or is draining this cycle.
  always_comb begin
    rdy = !q.v || gnt;
  end

  // Load on handshake (except r0), otherwise clear the entry once it is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (vld && rdy && (wa != RF_ZERO_REG)) begin
      q <= '{v: 1'b1, wa: wa, wd: wd};
    end else if (gnt) begin
      q.v <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Requester 0 is the ALU write-back and requester 1 is the load/memory write-back.
// Optional macro RF_ARB_PEND_EN adds pend_mask, which marks registers with a write
// still in flight (in either skid or in the output stage).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_vld,
  input  logic [AW-1:0]        alu_wa,
  input  logic [DW-1:0]        alu_wd,
  output logic                 alu_rdy,
  input  logic                 mem_vld,
  input  logic [AW-1:0]        mem_wa,
  input  logic [DW-1:0]        mem_wd,
  output logic                 mem_rdy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
`ifdef RF_ARB_PEND_EN
  output logic [(2**AW)-1:0]   pend_mask,
`endif
  output logic                 idle
);

  wb_req_t skid_0;
  wb_req_t skid_1;
  logic    gnt_0;
  logic    gnt_1;
  logic    rr_last;

  wb_skid u_skid_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (alu_vld),
    .wa    (alu_wa),
    .wd    (alu_wd),
    .gnt   (gnt_0),
    .rdy   (alu_rdy),
    .q     (skid_0)
  );

  wb_skid u_skid_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (mem_vld),
    .wa    (mem_wa),
    .wd    (mem_wd),
    .gnt   (gnt_1),
    .rdy   (mem_rdy),
    .q     (skid_1)
  );

  // Grant from registered state only; on contention the requester not served last wins.
  always_comb begin
    gnt_0 = skid_0.v && (!skid_1.v || rr_last);
    gnt_1 = skid_1.v && (!skid_0.v || !rr_last);
  end

  // Output stage and round-robin pointer; rr_last resets to 1 so the ALU wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_wa   <= '0;
      rf_wd   <= '0;
      rr_last <= 1'b1;
    end else if (gnt_0) begin
      rf_we   <= 1'b1;
      rf_wa   <= skid_0.wa;
      rf_wd   <= skid_0.wd;
      rr_last <= 1'b0;
    end else if (gnt_1) begin
      rf_we   <= 1'b1;
      rf_wa   <= skid_1.wa;
      rf_wd   <= skid_1.wd;
      rr_last <= 1'b1;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Nothing buffered and nothing being written.
  always_comb begin
    idle = !skid_0.v && !skid_1.v && !rf_we;
  end

`ifdef RF_ARB_PEND_EN
  // Registers with an outstanding write; r0 is never pending since its writes are dropped.
  always_comb begin
    pend_mask = '0;
    if (skid_0.v) pend_mask[skid_0.wa] = 1'b1;
    if (skid_1.v) pend_mask[skid_1.wa] = 1'b1;
    if (rf_we)    pend_mask[rf_wa]     = 1'b1;
    pend_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_vld;
  logic [3:0] alu_wa;
  logic [7:0] alu_wd;
  logic       alu_rdy;
  logic       mem_vld;
  logic [3:0] mem_wa;
  logic [7:0] mem_wd;
  logic       mem_rdy;
  logic       rf_we;
  logic [3:0] rf_wa;
  logic [7:0] rf_wd;
  logic       idle;
`ifdef RF_ARB_PEND_EN
  logic [15:0] pend_mask;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cnt_alu;
  int cnt_mem;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_vld   (alu_vld),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .alu_rdy   (alu_rdy),
    .mem_vld   (mem_vld),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .mem_rdy   (mem_rdy),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
`ifdef RF_ARB_PEND_EN
    .pend_mask (pend_mask),
`endif
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // Fixed: always runs to the summary and $finish.
  initial begin
    rst_n = 1'b0; alu_vld = 0; alu_wa = 0; alu_wd = 0;
    mem_vld = 0; mem_wa = 0; mem_wd = 0;
    #12;
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_alu_rdy", alu_rdy, 1);
    chk("rst_mem_rdy", mem_rdy, 1);
    chk("rst_idle", idle, 1);
    rst_n = 1'b1;
    step();

    // single uncontended ALU write
    alu_vld = 1; alu_wa = 3; alu_wd = 8'h5A;
    chk("t1_rdy_pre", alu_rdy, 1);
    step();
    alu_vld = 0;
    chk("t1_rdy_post", alu_rdy, 1);
    chk("t1_we_e0", rf_we, 0);
    chk("t1_idle_e0", idle, 0);
    step();
    chk("t1_we", rf_we, 1);
    chk("t1_wa", rf_wa, 3);
    chk("t1_wd", rf_wd, 8'h5A);
    step();
    chk("t1_we_off", rf_we, 0);
    chk("t1_wa_hold", rf_wa, 3);
    chk("t1_idle", idle, 1);

    // contention: alternate grants, ALU first after reset
    do_reset();
    alu_vld = 1; alu_wa = 1; alu_wd = 8'h11;
    mem_vld = 1; mem_wa = 2; mem_wd = 8'h22;
    cnt_alu = 0; cnt_mem = 0;
    for (int k = 1; k <= 8; k++) begin
      chk("t2_alu_rdy", alu_rdy, (k == 1) || (k % 2 == 0));
      chk("t2_mem_rdy", mem_rdy, (k == 1) || (k % 2 == 1));
      step();
      if (k >= 2) begin
        chk("t2_we", rf_we, 1);
        chk("t2_wa", rf_wa, (k % 2 == 0) ? 1 : 2);
        chk("t2_wd", rf_wd, (k % 2 == 0) ? 8'h11 : 8'h22);
      end
      if (rf_we && rf_wa == 1) cnt_alu++;
      if (rf_we && rf_wa == 2) cnt_mem++;
    end
    alu_vld = 0; mem_vld = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (rf_we && rf_wa == 1) cnt_alu++;
      if (rf_we && rf_wa == 2) cnt_mem++;
    end
    chk("t2_alu_writes", cnt_alu, 5);
    chk("t2_mem_writes", cnt_mem, 4);
    chk("t2_idle", idle, 1);

    // write to r0 is dropped
    mem_vld = 1; mem_wa = 0; mem_wd = 8'hFF;
    chk("t3_mem_rdy", mem_rdy, 1);
    step();
    mem_vld = 0;
    chk("t3_idle0", idle, 1);
    chk("t3_we0", rf_we, 0);
    step();
    chk("t3_we1", rf_we, 0);
    chk("t3_idle1", idle, 1);

    // ALU back-to-back stream, full throughput
    for (int i = 0; i < 4; i++) begin
      alu_vld = 1; alu_wa = 4'(4 + i); alu_wd = 8'(8'h40 + i);
      chk("t4_rdy", alu_rdy, 1);
      step();
      if (i >= 1) begin
        chk("t4_we", rf_we, 1);
        chk("t4_wa", rf_wa, 4 + i - 1);
      end
    end
    alu_vld = 0;
    chk("t4_rdy_end", alu_rdy, 1);
    step();
    chk("t4_we_last", rf_we, 1);
    chk("t4_wa_last", rf_wa, 7);
    chk("t4_wd_last", rf_wd, 8'h43);
    step();
    chk("t4_we_off", rf_we, 0);

    // async reset with both skids occupied
    alu_vld = 1; alu_wa = 8; alu_wd = 8'h88;
    mem_vld = 1; mem_wa = 9; mem_wd = 8'h99;
    step();
    alu_vld = 0; mem_vld = 0;
    step();
    chk("t5_we_pre", rf_we, 1);
    chk("t5_idle_pre", idle, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_we_rst", rf_we, 0);
    chk("t5_wa_rst", rf_wa, 0);
    chk("t5_idle_rst", idle, 1);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_we_after", rf_we, 0);
      chk("t5_idle_after", idle, 1);
    end

`ifdef RF_ARB_PEND_EN
    // pending mask while MEM wins and ALU wa=9 waits
    do_reset();
    alu_vld = 1; alu_wa = 10; alu_wd = 8'hA0;
    step();
    alu_wa = 9; alu_wd = 8'h90;
    mem_vld = 1; mem_wa = 5; mem_wd = 8'h50;
    step();
    alu_vld = 0; mem_vld = 0;
    chk("t6_mask_a", pend_mask, 16'h0620);
    step();
    chk("t6_mask_b", pend_mask, 16'h0220);
    chk("t6_wa_b", rf_wa, 5);
    step();
    chk("t6_wa_c", rf_wa, 9);
    chk("t6_mask_c", pend_mask, 16'h0200);
    step();
    chk("t6_mask_d", pend_mask, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
